// File: rtl/gpio_pkg.sv
// Shared constants, register map and helpers for the Wishbone GPIO controller.
// Register indices are word offsets (byte offset >> 2) inside the 256-byte window.
package gpio_pkg;

    localparam logic [31:0] GPIO_BASE_ADDR = 32'h3000_0000;
    localparam int          GPIO_NIO       = 38;

    typedef enum logic [5:0] {
        REG_OUT_LO      = 6'h00,
        REG_OUT_HI      = 6'h01,
        REG_OE_LO       = 6'h02,
        REG_OE_HI       = 6'h03,
        REG_IN_LO       = 6'h04,
        REG_IN_HI       = 6'h05,
        REG_IRQ_EN_LO   = 6'h06,
        REG_IRQ_STAT_LO = 6'h07
    } gpio_reg_e;

    // Replace only the byte lanes enabled in sel, keep the others from cur.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop input synchronizer with a rising-edge pulse on the synchronized value.
module gpio_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;

    // Synchronizer chain plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign q    = sync_r;
    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/wb_gpio_ctrl.sv
// Wishbone classic slave controlling NIO GPIO pads: output/enable registers,
// synchronized input readback and rising-edge interrupts on the low 32 pads.
module wb_gpio_ctrl
    import gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = GPIO_BASE_ADDR,
    parameter int          NIO       = GPIO_NIO
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    input  logic           wbs_cyc_i,
    input  logic           wbs_stb_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    input  logic [NIO-1:0] io_in,
    output logic [NIO-1:0] io_out,
    output logic [NIO-1:0] io_oeb,
    output logic [2:0]     user_irq
);

    localparam int HI_W = NIO - 32;

    logic [NIO-1:0]  in_sync_s;
    logic [NIO-1:0]  in_rise_s;
    logic            sel_s;
    logic            acc_s;
    logic            wr_s;
    gpio_reg_e       idx_s;
    logic [31:0]     rd_s;
    logic [31:0]     stat_clr_s;
    logic [31:0]     stat_set_s;
    logic            unused_s;

    logic [31:0]     out_lo_r;
    logic [HI_W-1:0] out_hi_r;
    logic [31:0]     oe_lo_r;
    logic [HI_W-1:0] oe_hi_r;
    logic [31:0]     irq_en_r;
    logic [31:0]     irq_stat_r;
    logic            ack_r;
    logic [31:0]     dat_r;
    logic [NIO-1:0]  io_out_r;
    logic [NIO-1:0]  io_oeb_r;
    logic            irq_r;

    gpio_sync #(
        .WIDTH (NIO)
    ) u_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .d     (io_in),
        .q     (in_sync_s),
        .rise  (in_rise_s)
    );

    // A transfer is accepted only while no ack is outstanding, which also
    // guarantees an idle cycle between consecutive acks.
    assign sel_s      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc_s      = sel_s & ~ack_r;
    assign wr_s       = acc_s & wbs_we_i;
    assign idx_s      = gpio_reg_e'(wbs_adr_i[7:2]);
    assign stat_set_s = in_rise_s[31:0] & irq_en_r;
    assign unused_s   = ^{wbs_adr_i[1:0], in_rise_s[NIO-1:32]};

    // Read data mux; unmapped offsets and unused upper bits read as zero.
    always_comb begin
        rd_s = 32'd0;
        case (idx_s)
            REG_OUT_LO:      rd_s = out_lo_r;
            REG_OUT_HI:      rd_s = 32'(out_hi_r);
            REG_OE_LO:       rd_s = oe_lo_r;
            REG_OE_HI:       rd_s = 32'(oe_hi_r);
            REG_IN_LO:       rd_s = in_sync_s[31:0];
            REG_IN_HI:       rd_s = 32'(in_sync_s[NIO-1:32]);
            REG_IRQ_EN_LO:   rd_s = irq_en_r;
            REG_IRQ_STAT_LO: rd_s = irq_stat_r;
            default:         rd_s = 32'd0;
        endcase
    end

    // Write-one-to-clear mask for the interrupt status register.
    always_comb begin
        stat_clr_s = 32'd0;
        if (wr_s && (idx_s == REG_IRQ_STAT_LO)) begin
            stat_clr_s = merge_bytes(32'd0, wbs_dat_i, wbs_sel_i);
        end else begin
            stat_clr_s = 32'd0;
        end
    end

    // Bus response: single-cycle ack with read data only alongside it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= acc_s;
            if (acc_s && !wbs_we_i) begin
                dat_r <= rd_s;
            end else begin
                dat_r <= 32'd0;
            end
        end
    end

    // Control register writes, committed on the acceptance edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_lo_r <= 32'd0;
            out_hi_r <= {HI_W{1'b0}};
            oe_lo_r  <= 32'd0;
            oe_hi_r  <= {HI_W{1'b0}};
            irq_en_r <= 32'd0;
        end else if (wr_s) begin
            case (idx_s)
                REG_OUT_LO:    out_lo_r <= merge_bytes(out_lo_r, wbs_dat_i, wbs_sel_i);
                REG_OUT_HI:    out_hi_r <= HI_W'(merge_bytes(32'(out_hi_r), wbs_dat_i, wbs_sel_i));
                REG_OE_LO:     oe_lo_r  <= merge_bytes(oe_lo_r, wbs_dat_i, wbs_sel_i);
                REG_OE_HI:     oe_hi_r  <= HI_W'(merge_bytes(32'(oe_hi_r), wbs_dat_i, wbs_sel_i));
                REG_IRQ_EN_LO: irq_en_r <= merge_bytes(irq_en_r, wbs_dat_i, wbs_sel_i);
                default:       ;
            endcase
        end
    end

    // Interrupt status: a new edge beats a simultaneous clear of the same bit.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_stat_r <= 32'd0;
        end else begin
            irq_stat_r <= (irq_stat_r & ~stat_clr_s) | stat_set_s;
        end
    end

    // Registered pad and interrupt outputs; pads stay tri-stated out of reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            io_out_r <= {NIO{1'b0}};
            io_oeb_r <= {NIO{1'b1}};
            irq_r    <= 1'b0;
        end else begin
            io_out_r <= {out_hi_r, out_lo_r};
            io_oeb_r <= ~{oe_hi_r, oe_lo_r};
            irq_r    <= |(irq_stat_r & irq_en_r);
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign io_out    = io_out_r;
    assign io_oeb    = io_oeb_r;
    assign user_irq  = {2'b00, irq_r};

endmodule

// File: doc/wb_gpio_ctrl.md
WB_GPIO_CTRL -- requirements
Module: wb_gpio_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; bits [7:0] SHALL be zero.
REQ-002 SHALL have parameter NIO, default 38, number of GPIO pads controlled.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock for all state.
REQ-004 SHALL have port wb_rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, each input, 1, Wishbone classic cycle, strobe and write-enable.
REQ-006 SHALL have port wbs_sel_i, input, 4, write byte-lane select.
REQ-007 SHALL have port wbs_adr_i, input, 32, byte address.
REQ-008 SHALL have port wbs_dat_i, input, 32, write data.
REQ-009 SHALL have ports wbs_ack_o, output, 1, and wbs_dat_o, output, 32, acknowledge and read data.
REQ-010 SHALL have ports io_in, input, NIO, pad inputs; io_out, output, NIO, pad outputs; io_oeb, output, NIO, pad output-enable (active low).
REQ-011 SHALL have port user_irq, output, 3, interrupt lines.

Function
REQ-012 SHALL select a transfer when cyc&stb are high and wbs_adr_i[31:8]==BASE_ADDR[31:8]; register index = wbs_adr_i[7:2].
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, the cycle after a selected transfer is first seen, then hold it low for at least one cycle (no back-to-back ack).
REQ-014 SHALL present read data on wbs_dat_o in the same cycle as ack, 0 in all other cycles.
REQ-015 SHALL not acknowledge unselected addresses.
REQ-016 SHALL decode the register map: 0x00 OUT_LO, 0x04 OUT_HI[NIO-33:0], 0x08 OE_LO, 0x0C OE_HI, 0x10 IN_LO (RO), 0x14 IN_HI (RO), 0x18 IRQ_EN_LO, 0x1C IRQ_STAT_LO (W1C).
REQ-017 SHALL write only the byte lanes enabled by wbs_sel_i; unused upper bits SHALL read 0.
REQ-018 SHALL ack offsets outside the map, read them as 0 and ignore writes to them.
REQ-019 SHALL drive io_out from OUT and io_oeb as ~OE, both registered.
REQ-020 SHALL double-flop synchronize io_in; IN SHALL read the synchronized value (2-cycle latency).
REQ-021 SHALL set IRQ_STAT[i] (i<32) on a rising edge of synchronized io_in[i] when IRQ_EN[i]=1.
REQ-022 SHALL clear IRQ_STAT bits written 1; on a simultaneous set and clear of the same bit, set wins.
REQ-023 SHALL drive user_irq[0] registered as |(IRQ_STAT & IRQ_EN), and user_irq[2:1] constant 0.
REQ-024 SHALL accept a drop of cyc/stb before ack: the pending ack still fires, and any write in it still commits.

Reset
REQ-025 SHALL, on wb_rst_ni low, asynchronously clear OUT, OE, IRQ_EN, IRQ_STAT, synchronizer flops, wbs_ack_o, wbs_dat_o and user_irq.
REQ-026 SHALL drive io_oeb all ones and io_out all zeros during and after reset.
REQ-027 SHALL, when reset is asserted mid-transfer, abandon the transfer with no ack and no register update.

Structure
REQ-028 SHALL place the register offsets, NIO default and BASE_ADDR default in shared package gpio_pkg.
REQ-029 SHALL instantiate one sub-module, gpio_sync (2-flop synchronizer plus rising-edge detect, width-parameterized).

Verification
REQ-030 SHALL cover: write 0xA5A5_A5A5 to 0x3000_0000 with sel=4'b0011 -> ack one cycle later; io_out[15:0]=0xA5A5 and io_out[31:16]=0.
REQ-031 SHALL cover: write OE_LO=0x0000_00FF -> io_oeb[7:0]=0 and io_oeb[37:8] all 1.
REQ-032 SHALL cover: io_in[3] 0->1 with IRQ_EN_LO=0x8 -> IRQ_STAT_LO=0x8 and user_irq[0]=1 within 4 cycles; W1C 0x8 -> user_irq[0]=0.
REQ-033 SHALL cover: W1C of bit 3 in the same cycle as a new rising edge on io_in[3] -> bit remains 1.
REQ-034 SHALL cover: read offset 0x40 -> ack with data 0; access to 0x3000_0100 -> no ack within 16 cycles.
REQ-035 SHALL cover: reset asserted between stb and ack -> no ack; io_oeb all 1; registers read back 0 after release.
